and_seq_gen: RTL

Stimulus generator that produces the other side of the start/a/b/stop sequence-composition protocol. It drives the a/b/stop sequence that the team's SVA `and` construct checker verifies.
On each rising edge of `start` it emits a timed burst:
- `b` one cycle after the trigger is sampled,
- `a` two cycles after,
- `stop` three cycles after.

Triggers arriving mid-burst are queued. It sits in the assertion-demo benches as the protocol driver, and in RTL wherever a start-triggered a/b/stop burst is needed.

---
 rtl/and_seq_pkg.sv | 22 ++
 rtl/seq_rise_det.sv | 19 +
 rtl/and_seq_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/and_seq_pkg.sv
// Shared types and constants for the start-triggered a/b/stop burst generator.
package and_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_B_DLY    = 1;
  localparam int DEF_A_DLY    = 2;
  localparam int DEF_STOP_DLY = 3;

  // Burst offsets are limited to 1..15, so the offset counter never needs more than 4 bits.
  localparam int CNT_BITS = $clog2(16);

  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/seq_rise_det.sv
// Registered 0->1 detector on start; en gates only the detected rise, not the history register.
module seq_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic start,
  output logic rise
);

  logic start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start;
  end

  assign rise = start & ~start_q & en;

endmodule

// File: rtl/and_seq_gen.sv
// Emits b/a/stop pulses at fixed offsets after each start rise, queueing rises that arrive mid-burst.
module and_seq_gen
  import and_seq_pkg::*;
#(
  parameter int B_DLY      = DEF_B_DLY,
  parameter int A_DLY      = DEF_A_DLY,
  parameter int STOP_DLY   = DEF_STOP_DLY,
  parameter int PEND_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            clr,
  input  logic                            start,
  output logic                            a,
  output logic                            b,
  output logic                            stop,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(PEND_DEPTH+1)-1:0] pend_cnt,
  output logic                            overrun,
  output logic [CNT_W-1:0]                drop_cnt
);

  localparam int MAX_DLY = max3(A_DLY, B_DLY, STOP_DLY);
  localparam int PEND_W  = $clog2(PEND_DEPTH + 1);

  localparam logic [CNT_BITS-1:0] A_C    = CNT_BITS'(A_DLY);
  localparam logic [CNT_BITS-1:0] B_C    = CNT_BITS'(B_DLY);
  localparam logic [CNT_BITS-1:0] STOP_C = CNT_BITS'(STOP_DLY);
  localparam logic [CNT_BITS-1:0] MAX_C  = CNT_BITS'(MAX_DLY);
  localparam logic [CNT_BITS-1:0] CNT_1  = CNT_BITS'(1);
  localparam logic [PEND_W-1:0]   PEND_MAX = PEND_W'(PEND_DEPTH);
  localparam logic [PEND_W-1:0]   PEND_1   = PEND_W'(1);
  localparam logic [CNT_W-1:0]    DROP_SAT = '1;
  localparam logic [CNT_W-1:0]    DROP_1   = CNT_W'(1);

  logic                rise;
  state_t              state, state_d;
  logic [CNT_BITS-1:0] cnt, cnt_d;
  logic [PEND_W-1:0]   pend_d;
  logic                overrun_d;
  logic [CNT_W-1:0]    drop_d;

  seq_rise_det u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .rise  (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_cnt <= '0;
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pend_cnt <= pend_d;
      overrun  <= overrun_d;
      drop_cnt <= drop_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pend_d    = pend_cnt;
    overrun_d = overrun;
    drop_d    = drop_cnt;
    if (clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      pend_d    = '0;
      overrun_d = 1'b0;
      drop_d    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_d = RUN;
            cnt_d   = CNT_1;
          end
        end
        RUN: begin
          if (cnt == MAX_C) begin
            // A rise on the final edge takes the slot this burst frees, so the queue depth is unchanged.
            if (rise) begin
              cnt_d = CNT_1;
            end else if (pend_cnt != '0) begin
              cnt_d  = CNT_1;
              pend_d = pend_cnt - PEND_1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt + CNT_1;
            if (rise) begin
              if (pend_cnt < PEND_MAX) begin
                pend_d = pend_cnt + PEND_1;
              end else begin
                overrun_d = 1'b1;
                if (drop_cnt != DROP_SAT) drop_d = drop_cnt + DROP_1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign b    = busy & (cnt == B_C);
  assign a    = busy & (cnt == A_C);
  assign stop = busy & (cnt == STOP_C);
  assign done = busy & (cnt == MAX_C);

endmodule
